// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: program memory port,
// redirect input and decoder-facing handshake.
interface instr_fetch_if #(
  parameter int width        = 5,
  parameter int addresswidth = 32
);
  logic [addresswidth-1:0] mem_addr;
  logic [width-1:0]        mem_data;
  logic                    jump_en;
  logic [addresswidth-1:0] jump_target;
  logic [width-1:0]        instr;
  logic [addresswidth-1:0] instr_pc;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [addresswidth-1:0] pc;
  logic                    halted;

  modport slave (
    output mem_addr,
    input  mem_data,
    input  jump_en,
    input  jump_target,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    output pc,
    output halted
  );

  modport master (
    input  mem_addr,
    output mem_data,
    output jump_en,
    output jump_target,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    input  pc,
    input  halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: issue, capture,
// hold until accepted, stop on the halt opcode.
module instr_fetch #(
  parameter int              width        = 5,
  parameter int              addresswidth = 32,
  parameter logic [width-1:0] HALT_OPCODE = 5'b11111
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    ISSUE,
    CAPTURE,
    VALID,
    HALT
  } state_e;

  localparam logic [addresswidth-1:0] PcOne =
    {{(addresswidth-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [addresswidth-1:0] pc_q, pc_d;
  logic [width-1:0]        instr_q, instr_d;
  logic [addresswidth-1:0] ipc_q, ipc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ISSUE;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      ISSUE: begin
        if (bus.jump_en) begin
          pc_d    = bus.jump_target;
          state_d = ISSUE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.jump_en) begin
          pc_d    = bus.jump_target;
          state_d = ISSUE;
        end else begin
          instr_d = bus.mem_data;
          ipc_d   = pc_q;
          pc_d    = pc_q + PcOne;
          state_d = VALID;
        end
      end
      VALID: begin
        // a redirect wins over both holding and halting
        if (bus.jump_en) begin
          pc_d    = bus.jump_target;
          state_d = ISSUE;
        end else if (bus.instr_ready) begin
          state_d = (instr_q == HALT_OPCODE) ? HALT : ISSUE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = (state_q == VALID);
  assign bus.halted      = (state_q == HALT);

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter width, default 5, meaning instruction entry width in bits, equal to the program memory width.
REQ-002 SHALL have parameter addresswidth, default 32, meaning program counter and memory address width.
REQ-003 SHALL have parameter HALT_OPCODE, default 5'b11111, meaning the instruction value that stops fetching.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports listed below.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 mem_addr  output  addresswidth  address driven to program memory addr.
REQ-008 mem_data  input  width  program memory data, valid the cycle after mem_addr is sampled.
REQ-009 jump_en  input  1  redirect request, sampled each rising edge.
REQ-010 jump_target  input  addresswidth  redirect address.
REQ-011 instr  output  width  held instruction to decoder.
REQ-012 instr_pc  output  addresswidth  address the held instruction came from.
REQ-013 instr_valid  output  1  instr/instr_pc valid.
REQ-014 instr_ready  input  1  decoder accepts instr this cycle.
REQ-015 pc  output  addresswidth  address of the next fetch.
REQ-016 halted  output  1  fetch stopped on HALT_OPCODE.

Function
REQ-017 SHALL implement FSM states ISSUE, CAPTURE, VALID, HALT.
REQ-018 SHALL drive mem_addr = pc combinationally in every state.
REQ-019 ISSUE: instr_valid=0; next state CAPTURE.
REQ-020 CAPTURE: instr <= mem_data, instr_pc <= pc, pc <= pc+1; next state VALID.
REQ-021 VALID: instr_valid=1; instr, instr_pc and pc held stable while instr_ready=0.
REQ-022 VALID with instr_ready=1: handshake completes; next state HALT if instr==HALT_OPCODE, else ISSUE.
REQ-023 Throughput SHALL be one instruction per 3 cycles with instr_ready held high; instr_valid rises 2 edges after entering ISSUE.
REQ-024 pc+1 SHALL wrap modulo 2^addresswidth (all-ones -> 0).
REQ-025 jump_en=1 in ISSUE, CAPTURE or VALID SHALL set pc <= jump_target, discard any in-flight or held instruction, and go to ISSUE; instr_valid=0 next cycle.
REQ-026 jump_en in VALID with instr_ready=1: the held instruction counts as consumed, then the jump applies; jump beats HALT transition.
REQ-027 jump_en in CAPTURE: the captured value SHALL never be presented with instr_valid=1.
REQ-028 HALT: halted=1, instr_valid=0, pc frozen; jump_en ignored; only reset exits.
REQ-029 Priority SHALL be reset > jump_en > normal sequencing.

Reset
REQ-030 reset=1 at a rising edge SHALL set state=ISSUE, pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, in any state including mid-handshake.
REQ-031 reset SHALL override jump_en and instr_ready on the same edge; fetch of address 0 starts the cycle after reset deasserts.

Verification (program memory preloaded mem[i]=i, mem[31]=5'b11111)
REQ-032 Reset, then instr_ready=1 -> instr_valid first high 2 edges after reset release with instr=0, instr_pc=0; next valid 3 cycles later instr=1, instr_pc=1, pc=2.
REQ-033 Hold instr_ready=0 for 5 cycles in VALID -> instr, instr_pc, pc, instr_valid=1 unchanged each cycle; accept on cycle 6 -> ISSUE next.
REQ-034 jump_en=1, jump_target=9 in VALID with instr_ready=1 -> next delivered instr=5'b01001, instr_pc=9, pc=10.
REQ-035 jump_en=1, jump_target=9 in CAPTURE -> no valid for old address; next valid instr=5'b01001, instr_pc=9.
REQ-036 Jump to 31, accept 5'b11111 -> halted=1 next cycle, instr_valid=0 thereafter; jump_en ignored; reset -> halted=0, pc=0.
REQ-037 addresswidth=4 instance, jump to 15 -> after CAPTURE pc=0; reset asserted during VALID -> next cycle instr_valid=0, pc=0.
